// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 BCM panel driver.
package hub75_pkg;

  // Base SHOW window length in clocks for bit-plane 0; plane p lasts OE_UNIT<<p.
  localparam int OE_UNIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_SHOW
  } state_t;

  // Bit position of plane p inside a {R,G,B} pixel word of bpc bits per colour.
  function automatic int red_ofs(input int p, input int bpc);
    return 2 * bpc + p;
  endfunction

  function automatic int green_ofs(input int p, input int bpc);
    return bpc + p;
  endfunction

  function automatic int blue_ofs(input int p, input int bpc);
    return p;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// SHOW-window timer: one window of OE_UNIT<<plane clocks, output enabled
// for the first (brightness+1)<<plane of them.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BPC     = 4,
  parameter int PLANE_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [PLANE_W-1:0] i_plane,
  input  logic [3:0]         i_brightness,
  output logic               o_oe_on,
  output logic               o_window_done
);

  localparam int CNT_W = 4 + BPC;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_on_len;
  logic [CNT_W-1:0] r_win_last;
  logic             r_active;
  logic             r_oe_on;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign o_window_done = r_active && (r_cnt == r_win_last);
  assign o_oe_on       = r_oe_on;

  // Load window geometry at SHOW entry, then count it out; oe_on is a flop so
  // it lines up with the cycles the FSM spends in SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_on_len   <= '0;
      r_win_last <= '0;
      r_active   <= 1'b0;
      r_oe_on    <= 1'b0;
    end else if (i_load) begin
      r_cnt      <= '0;
      r_on_len   <= (CNT_W'(i_brightness) + CNT_W'(1)) << i_plane;
      r_win_last <= (CNT_W'(OE_UNIT) << i_plane) - CNT_W'(1);
      r_active   <= 1'b1;
      r_oe_on    <= 1'b1;
    end else if (r_active) begin
      r_cnt <= w_cnt_inc;
      if (o_window_done) begin
        r_active <= 1'b0;
        r_oe_on  <= 1'b0;
      end else begin
        r_oe_on <= (w_cnt_inc < r_on_len);
      end
    end
  end

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scanner with binary-coded modulation, global brightness,
// run/stop control and a frame-done strobe. Reads pixels from an external
// synchronous framebuffer with one cycle of read latency.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int COLS      = 32,
  parameter int ADDR_BITS = 4,
  parameter int BPC       = 4,
  parameter int COL_BITS  = $clog2(COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [3:0]                    brightness,
  output logic [ADDR_BITS+COL_BITS-1:0] fb_addr,
  input  logic [3*BPC-1:0]              fb_rdata_top,
  input  logic [3*BPC-1:0]              fb_rdata_bot,
  output logic [ADDR_BITS-1:0]          row_addr,
  output logic                          r0,
  output logic                          g0,
  output logic                          b0,
  output logic                          r1,
  output logic                          g1,
  output logic                          b1,
  output logic                          sclk,
  output logic                          lat,
  output logic                          oe_n,
  output logic                          frame_done
);

  localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int K_W     = COL_BITS + 2;
  localparam logic [K_W-1:0]      K_LAST     = K_W'(2 * COLS);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(BPC - 1);
  localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(COLS - 1);

  state_t                        r_state, w_state_nxt;
  logic [K_W-1:0]                r_k;
  logic [ADDR_BITS-1:0]          r_row, w_row_nxt, r_row_addr;
  logic [PLANE_W-1:0]            r_plane, w_plane_nxt;
  logic                          w_frame_end;
  logic [ADDR_BITS+COL_BITS-1:0] r_fb_addr;
  logic [5:0]                    r_rgb;
  logic                          r_sclk, r_lat, r_frame_done;
  logic [COL_BITS-1:0]           w_col;
  logic                          w_load, w_oe_on, w_window_done;

  // Select one bit of a pixel word by position.
  function automatic logic pick(input logic [3*BPC-1:0] px, input int ofs);
    logic [3*BPC-1:0] sh;
    sh = px >> ofs;
    return sh[0];
  endfunction

  // Odd k samples column k>>1; even k is the sclk-high half.
  assign w_col  = r_k[COL_BITS:1];
  assign w_load = (r_state == ST_LATCH);

  hub75_bcm_timer #(
    .BPC     (BPC),
    .PLANE_W (PLANE_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst),
    .i_load        (w_load),
    .i_plane       (r_plane),
    .i_brightness  (brightness),
    .o_oe_on       (w_oe_on),
    .o_window_done (w_window_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state plus the plane/row successor used at SHOW exit.
  always_comb begin
    w_state_nxt = r_state;
    w_plane_nxt = r_plane + PLANE_W'(1);
    w_row_nxt   = r_row;
    w_frame_end = 1'b0;
    if (r_plane == PLANE_LAST) begin
      w_plane_nxt = '0;
      w_row_nxt   = r_row + ADDR_BITS'(1);
      w_frame_end = &r_row;
    end
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_k == K_LAST) w_state_nxt = ST_BLANK;
      ST_BLANK: w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_SHOW;
      ST_SHOW:  if (w_window_done) w_state_nxt = en ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift/latch datapath and scan counters; every panel pin comes from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k          <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_row_addr   <= '0;
      r_fb_addr    <= '0;
      r_rgb        <= '0;
      r_sclk       <= 1'b0;
      r_lat        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_lat        <= (w_state_nxt == ST_LATCH);
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_row     <= '0;
            r_plane   <= '0;
            r_k       <= '0;
            r_fb_addr <= '0;
          end
        end
        ST_SHIFT: begin
          r_k <= r_k + K_W'(1);
          if (r_k[0]) begin
            r_rgb <= {pick(fb_rdata_top, red_ofs(int'(r_plane), BPC)),
                      pick(fb_rdata_top, green_ofs(int'(r_plane), BPC)),
                      pick(fb_rdata_top, blue_ofs(int'(r_plane), BPC)),
                      pick(fb_rdata_bot, red_ofs(int'(r_plane), BPC)),
                      pick(fb_rdata_bot, green_ofs(int'(r_plane), BPC)),
                      pick(fb_rdata_bot, blue_ofs(int'(r_plane), BPC))};
            r_sclk <= 1'b1;
            if (w_col != COL_LAST) r_fb_addr <= {r_row, w_col + COL_BITS'(1)};
          end else begin
            r_sclk <= 1'b0;
          end
        end
        ST_BLANK: r_row_addr <= r_row;
        ST_SHOW: begin
          if (w_window_done) begin
            r_plane      <= w_plane_nxt;
            r_row        <= w_row_nxt;
            r_frame_done <= w_frame_end;
            r_k          <= '0;
            r_fb_addr    <= {w_row_nxt, COL_BITS'(0)};
          end
        end
        default: ;
      endcase
    end
  end

  assign fb_addr                  = r_fb_addr;
  assign row_addr                 = r_row_addr;
  assign {r0, g0, b0, r1, g1, b1} = r_rgb;
  assign sclk                     = r_sclk;
  assign lat                      = r_lat;
  assign oe_n                     = ~w_oe_on;
  assign frame_done               = r_frame_done;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver with COLS=4, ADDR_BITS=1, BPC=2.
module tb_hub75_bcm_driver;

  localparam int COLS = 4, ADDR_BITS = 1, BPC = 2, COL_BITS = 2;
  localparam int AW = ADDR_BITS + COL_BITS;
  localparam int LOG_N = 700;
  localparam int P_R0 = 0, P_G0 = 1, P_B0 = 2, P_R1 = 3, P_G1 = 4, P_B1 = 5;
  localparam int P_OE = 6, P_LAT = 7, P_SCLK = 8, P_FD = 9;

  logic clk = 1'b0;
  logic rst, en;
  logic [3:0] brightness;
  logic [AW-1:0] fb_addr;
  logic [3*BPC-1:0] fb_rdata_top, fb_rdata_bot;
  logic [ADDR_BITS-1:0] row_addr;
  logic r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, frame_done;

  logic [3*BPC-1:0] top_mem [0:7];
  logic [3*BPC-1:0] bot_mem [0:7];

  logic [9:0]           lg      [0:LOG_N-1];
  logic [ADDR_BITS-1:0] lg_row  [0:LOG_N-1];
  logic [AW-1:0]        lg_addr [0:LOG_N-1];
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;

  hub75_bcm_driver #(
    .COLS(COLS), .ADDR_BITS(ADDR_BITS), .BPC(BPC), .COL_BITS(COL_BITS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness),
    .fb_addr(fb_addr), .fb_rdata_top(fb_rdata_top), .fb_rdata_bot(fb_rdata_bot),
    .row_addr(row_addr), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .sclk(sclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer, one cycle read latency.
  always @(posedge clk) begin
    fb_rdata_top <= top_mem[fb_addr];
    fb_rdata_bot <= bot_mem[fb_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      lg[cyc]      = {frame_done, sclk, lat, oe_n, b1, g1, r1, b0, g0, r0};
      lg_row[cyc]  = row_addr;
      lg_addr[cyc] = fb_addr;
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic int cnt(input int pos, input logic val, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (lg[i][pos] === val) n++;
    return n;
  endfunction

  function automatic int rises(input int pos, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) if (lg[i][pos] === 1'b1 && lg[i-1][pos] === 1'b0) n++;
    return n;
  endfunction

  // Value on the four sclk-high cycles of a plane starting at s, column 0 as MSB.
  function automatic int pat(input int pos, input int s);
    int v = 0;
    for (int c = 0; c < 4; c++) v = (v << 1) | int'(lg[s + 2 + 2 * c][pos]);
    return v;
  endfunction

  initial begin
    int idle_bad;
    int row_chg;
    int row_viol;
    for (int i = 0; i < 8; i++) begin
      top_mem[i] = '0;
      bot_mem[i] = '0;
    end
    top_mem[0] = 6'b01_00_00;
    top_mem[2] = 6'b01_00_00;
    top_mem[7] = 6'b00_00_11;
    bot_mem[1] = 6'b00_10_00;

    rst = 1'b0;
    en = 1'b0;
    brightness = 4'd15;
    repeat (3) @(negedge clk);
    check("rst_oe_n", oe_n, 1);
    check("rst_lat", lat, 0);
    check("rst_sclk", sclk, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_r0", r0, 0);

    rst = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oe_n !== 1'b1 || lat !== 1'b0 || sclk !== 1'b0 || row_addr !== '0) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    en = 1'b1;
    @(negedge clk);
    capture(280);
    brightness = 4'd0;
    capture(142);
    brightness = 4'd15;
    capture(70);
    en = 1'b0;
    capture(108);
    en = 1'b1;
    capture(41);

    // Shift data
    check("r0_row0_p0", pat(P_R0, 0), 4'b1010);
    check("r0_row0_p1", pat(P_R0, 27), 4'b0000);
    check("g1_row0_p0", pat(P_G1, 0), 4'b0000);
    check("g1_row0_p1", pat(P_G1, 27), 4'b0100);
    check("b0_row1_p0", pat(P_B0, 70), 4'b0001);
    check("b0_row1_p1", pat(P_B0, 97), 4'b0001);
    check("r0_row1_p0", pat(P_R0, 70), 4'b0000);
    check("sclk_pulses_p0", rises(P_SCLK, 1, 27), 4);
    check("sclk_pulses_p1", rises(P_SCLK, 27, 70), 4);
    check("lat_pulses_p0", cnt(P_LAT, 1'b1, 0, 27), 1);
    check("lat_at_10", lg[10][P_LAT], 1);
    check("fb_addr_c0", lg_addr[0], 0);
    check("fb_addr_c1", lg_addr[2], 1);
    check("fb_addr_held", lg_addr[8], 3);
    check("fb_addr_row1", lg_addr[70], 4);
    check("fb_addr_row1_c1", lg_addr[72], 5);

    // BCM / brightness
    check("oe_b15_p0", cnt(P_OE, 1'b0, 0, 27), 16);
    check("oe_b15_p1", cnt(P_OE, 1'b0, 27, 70), 32);
    check("oe_latch_high", lg[10][P_OE], 1);
    check("oe_show_start", lg[11][P_OE], 0);
    check("oe_b0_p0", cnt(P_OE, 1'b0, 280, 307), 1);
    check("oe_b0_p0_at", lg[291][P_OE], 0);
    check("oe_b0_p1", cnt(P_OE, 1'b0, 307, 350), 2);
    check("oe_b0_p1_at0", lg[318][P_OE], 0);
    check("oe_b0_p1_at1", lg[319][P_OE], 0);

    // Frame timing and row address
    check("fd_count", cnt(P_FD, 1'b1, 0, 422), 3);
    check("fd_140", lg[140][P_FD], 1);
    check("fd_280", lg[280][P_FD], 1);
    check("fd_420", lg[420][P_FD], 1);
    check("row_at_79", lg_row[79], 0);
    check("row_at_80", lg_row[80], 1);
    check("row_at_150", lg_row[150], 0);
    row_chg = 0;
    row_viol = 0;
    for (int i = 1; i < 422; i++) begin
      if (lg_row[i] !== lg_row[i-1]) begin
        row_chg++;
        if (lg[i][P_OE] !== 1'b1 || lg[i-1][P_OE] !== 1'b1) row_viol++;
      end
    end
    check("row_changes", row_chg, 5);
    check("row_change_blanked", row_viol, 0);

    // Stop and restart
    check("stop_show_done", cnt(P_OE, 1'b0, 490, 517), 16);
    check("stop_idle_oe", cnt(P_OE, 1'b0, 517, 600), 0);
    check("stop_idle_sclk", rises(P_SCLK, 517, 600), 0);
    check("stop_idle_lat", cnt(P_LAT, 1'b1, 517, 600), 0);
    check("stop_row_held", lg_row[599], 1);
    check("stop_no_fd", cnt(P_FD, 1'b1, 422, 600), 0);
    check("restart_addr", lg_addr[601], 0);
    check("restart_sclk", lg[603][P_SCLK], 1);
    check("restart_r0", lg[603][P_R0], 1);
    check("restart_row_old", lg_row[605], 1);
    check("restart_row_new", lg_row[611], 0);
    check("restart_oe", lg[612][P_OE], 0);

    // Asynchronous reset in the middle of a lit SHOW window
    check("pre_rst_oe", oe_n, 0);
    #1 rst = 1'b0;
    #1;
    check("async_oe_n", oe_n, 1);
    check("async_lat", lat, 0);
    check("async_row", row_addr, 0);
    check("async_sclk", sclk, 0);
    check("async_fb_addr", fb_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
